get_reg_name: RTL and testbench

- Translates RISC-V integer register indices to ABI register-name strings, and ABI names back to indices.
- Used by the execute-stage debug and trace logic, for example register-file dumps and per-instruction trace printing.
- Purely a lookup block with registered outputs. It holds no architectural state.

---
 rtl/reg_name_pkg.sv | 24 ++
 rtl/abi_name_rom.sv | 41 ++++
 rtl/get_reg_name.sv | 66 ++++++
 tb/tb_get_reg_name.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_name_pkg.sv
// Shared constants for RISC-V ABI register naming: packed name type and lookup table.
// Pure constants; no latency, no flow control.
package reg_name_pkg;

    localparam int NUM_GPR = 32;

    typedef logic [31:0] name_t;

    // Right-justified ASCII, unused high bytes zero.
    localparam name_t NAME_TABLE [0:NUM_GPR-1] = '{
        32'h7A65_726F, 32'h0000_7261, 32'h0000_7370, 32'h0000_6770,
        32'h0000_7470, 32'h0000_7430, 32'h0000_7431, 32'h0000_7432,
        32'h0000_7330, 32'h0000_7331, 32'h0000_6130, 32'h0000_6131,
        32'h0000_6132, 32'h0000_6133, 32'h0000_6134, 32'h0000_6135,
        32'h0000_6136, 32'h0000_6137, 32'h0000_7332, 32'h0000_7333,
        32'h0000_7334, 32'h0000_7335, 32'h0000_7336, 32'h0000_7337,
        32'h0000_7338, 32'h0000_7339, 32'h0073_3130, 32'h0073_3131,
        32'h0000_7433, 32'h0000_7434, 32'h0000_7435, 32'h0000_7436
    };

    localparam name_t NAME_UNKNOWN = 32'h003F_3F3F;
    localparam name_t NAME_FP      = 32'h0000_6670;

endpackage

// File: rtl/abi_name_rom.sv
// Combinational index->name table read and name->index compare/encode.
// Zero latency; no flow control.
module abi_name_rom
    import reg_name_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic [IDX_W-1:0] fwd_idx,
    output name_t            fwd_name,
    output logic             fwd_err,
    input  name_t            rev_name,
    output logic [IDX_W-1:0] rev_idx,
    output logic             rev_err
);

    always_comb begin
        fwd_err  = 1'b0;
        fwd_name = NAME_TABLE[fwd_idx[4:0]];
        if (fwd_idx > IDX_W'(NUM_GPR - 1)) begin
            fwd_err  = 1'b1;
            fwd_name = NAME_UNKNOWN;
        end
    end

    // Table entries are unique, so at most one compare hits; fp aliases s0.
    always_comb begin
        rev_idx = '0;
        rev_err = 1'b1;
        for (int i = 0; i < NUM_GPR; i++) begin
            if (rev_name == NAME_TABLE[i]) begin
                rev_idx = IDX_W'(i);
                rev_err = 1'b0;
            end
        end
        if (rev_name == NAME_FP) begin
            rev_idx = IDX_W'(8);
            rev_err = 1'b0;
        end
    end

endmodule

// File: rtl/get_reg_name.sv
// RISC-V register index <-> ABI name translator with registered outputs.
// Latency 1 cycle on each independent path; no backpressure, accepts every cycle.
module get_reg_name
    import reg_name_pkg::*;
#(
    parameter int IDX_W  = 6,
    parameter int NAME_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fwd_valid,
    input  logic [IDX_W-1:0]  fwd_idx,
    output logic              fwd_name_valid,
    output logic [NAME_W-1:0] fwd_name,
    output logic              fwd_err,
    input  logic              rev_valid,
    input  logic [NAME_W-1:0] rev_name,
    output logic              rev_idx_valid,
    output logic [IDX_W-1:0]  rev_idx,
    output logic              rev_err
);

    name_t            lut_fwd_name;
    logic             lut_fwd_err;
    logic [IDX_W-1:0] lut_rev_idx;
    logic             lut_rev_err;

    abi_name_rom #(.IDX_W(IDX_W)) u_rom (
        .fwd_idx  (fwd_idx),
        .fwd_name (lut_fwd_name),
        .fwd_err  (lut_fwd_err),
        .rev_name (rev_name),
        .rev_idx  (lut_rev_idx),
        .rev_err  (lut_rev_err)
    );

    // Payload holds its last value when no request is presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_name_valid <= 1'b0;
            fwd_name       <= '0;
            fwd_err        <= 1'b0;
        end else begin
            fwd_name_valid <= fwd_valid;
            if (fwd_valid) begin
                fwd_name <= lut_fwd_name;
                fwd_err  <= lut_fwd_err;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rev_idx_valid <= 1'b0;
            rev_idx       <= '0;
            rev_err       <= 1'b0;
        end else begin
            rev_idx_valid <= rev_valid;
            if (rev_valid) begin
                rev_idx <= lut_rev_idx;
                rev_err <= lut_rev_err;
            end
        end
    end

endmodule

// File: tb/tb_get_reg_name.sv
// Directed bench for get_reg_name: reset, forward/reverse lookup, concurrency, round trip.
module tb_get_reg_name;

    logic        clk = 1'b0;
    logic        reset;
    logic        fwd_valid;
    logic [5:0]  fwd_idx;
    logic        fwd_name_valid;
    logic [31:0] fwd_name;
    logic        fwd_err;
    logic        rev_valid;
    logic [31:0] rev_name;
    logic        rev_idx_valid;
    logic [5:0]  rev_idx;
    logic        rev_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    get_reg_name dut (
        .clk            (clk),
        .reset          (reset),
        .fwd_valid      (fwd_valid),
        .fwd_idx        (fwd_idx),
        .fwd_name_valid (fwd_name_valid),
        .fwd_name       (fwd_name),
        .fwd_err        (fwd_err),
        .rev_valid      (rev_valid),
        .rev_name       (rev_name),
        .rev_idx_valid  (rev_idx_valid),
        .rev_idx        (rev_idx),
        .rev_err        (rev_err)
    );

    function automatic logic [31:0] exp_name(input int i);
        case (i)
            0:  return 32'h7A65_726F;  1:  return 32'h0000_7261;
            2:  return 32'h0000_7370;  3:  return 32'h0000_6770;
            4:  return 32'h0000_7470;  5:  return 32'h0000_7430;
            6:  return 32'h0000_7431;  7:  return 32'h0000_7432;
            8:  return 32'h0000_7330;  9:  return 32'h0000_7331;
            10: return 32'h0000_6130;  11: return 32'h0000_6131;
            12: return 32'h0000_6132;  13: return 32'h0000_6133;
            14: return 32'h0000_6134;  15: return 32'h0000_6135;
            16: return 32'h0000_6136;  17: return 32'h0000_6137;
            18: return 32'h0000_7332;  19: return 32'h0000_7333;
            20: return 32'h0000_7334;  21: return 32'h0000_7335;
            22: return 32'h0000_7336;  23: return 32'h0000_7337;
            24: return 32'h0000_7338;  25: return 32'h0000_7339;
            26: return 32'h0073_3130;  27: return 32'h0073_3131;
            28: return 32'h0000_7433;  29: return 32'h0000_7434;
            30: return 32'h0000_7435;  31: return 32'h0000_7436;
            default: return 32'h003F_3F3F;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        n_cmp++;
        if ({fwd_name_valid, fwd_name, fwd_err, rev_idx_valid, rev_idx, rev_err} !== 41'd0) begin
            n_bad++;
            $display("FAIL %s: got fv=%b fn=%h fe=%b rv=%b ri=%0d re=%b, expected all zero",
                     tag, fwd_name_valid, fwd_name, fwd_err, rev_idx_valid, rev_idx, rev_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; fwd_valid = 1'b0; fwd_idx = '0; rev_valid = 1'b0; rev_name = '0;
        #12;
        check_all_zero("reset_initial");
        reset = 1'b1;
        step();
        fwd_valid = 1'b1; fwd_idx = 6'd5;
        rev_valid = 1'b1; rev_name = 32'h0000_7837;
        step();
        n_cmp++;
        if (fwd_name !== 32'h0000_7430 || rev_err !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset: got fn=%h re=%b, expected 00007430 1", fwd_name, rev_err);
        end
        rev_name = 32'h0000_7436;
        step();
        // assert reset mid-cycle with requests still present
        #2 reset = 1'b0;
        #1 check_all_zero("reset_async");
        step();
        check_all_zero("reset_held_drop");
        @(negedge clk);
        reset = 1'b1; fwd_idx = 6'd0; rev_valid = 1'b0;
        step();
        n_cmp++;
        if (fwd_name !== 32'h7A65_726F || fwd_name_valid !== 1'b1 || fwd_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_first_req: got fn=%h fv=%b fe=%b, expected 7a65726f 1 0",
                     fwd_name, fwd_name_valid, fwd_err);
        end
    endtask

    task automatic test_fwd_sweep();
        rev_valid = 1'b0;
        fwd_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            fwd_idx = 6'(i);
            step();
            n_cmp++;
            if (fwd_name !== exp_name(i) || fwd_name_valid !== 1'b1 || fwd_err !== 1'b0) begin
                n_bad++;
                $display("FAIL fwd_sweep[%0d]: got fn=%h fv=%b fe=%b, expected %h 1 0",
                         i, fwd_name, fwd_name_valid, fwd_err, exp_name(i));
            end
        end
    endtask

    task automatic test_fwd_range();
        fwd_valid = 1'b1; fwd_idx = 6'd40;
        step();
        n_cmp++;
        if (fwd_name !== 32'h003F_3F3F || fwd_err !== 1'b1 || fwd_name_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL fwd_oor: got fn=%h fe=%b fv=%b, expected 003f3f3f 1 1",
                     fwd_name, fwd_err, fwd_name_valid);
        end
        fwd_valid = 1'b0; fwd_idx = 6'd3;
        step();
        n_cmp++;
        if (fwd_name_valid !== 1'b0 || fwd_name !== 32'h003F_3F3F || fwd_err !== 1'b1) begin
            n_bad++;
            $display("FAIL fwd_hold: got fv=%b fn=%h fe=%b, expected 0 003f3f3f 1",
                     fwd_name_valid, fwd_name, fwd_err);
        end
        fwd_valid = 1'b1; fwd_idx = 6'd32;
        step();
        n_cmp++;
        if (fwd_name !== 32'h003F_3F3F || fwd_err !== 1'b1) begin
            n_bad++;
            $display("FAIL fwd_oor32: got fn=%h fe=%b, expected 003f3f3f 1", fwd_name, fwd_err);
        end
        fwd_valid = 1'b0;
    endtask

    task automatic test_reverse();
        logic [31:0] names [7];
        logic [5:0]  idxs  [7];
        logic        errs  [7];
        names = '{32'h0000_6130, 32'h0000_6670, 32'h0000_7436, 32'h0000_7837,
                  32'h0000_4130, 32'h0100_6130, 32'h0073_3130};
        idxs  = '{6'd10, 6'd8, 6'd31, 6'd0, 6'd0, 6'd0, 6'd26};
        errs  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        rev_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            rev_name = names[k];
            step();
            n_cmp++;
            if (rev_idx !== idxs[k] || rev_err !== errs[k] || rev_idx_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL rev[%h]: got ri=%0d re=%b rv=%b, expected %0d %b 1",
                         names[k], rev_idx, rev_err, rev_idx_valid, idxs[k], errs[k]);
            end
        end
        rev_valid = 1'b0; rev_name = 32'h0000_7261;
        step();
        n_cmp++;
        if (rev_idx_valid !== 1'b0 || rev_idx !== 6'd26 || rev_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rev_hold: got rv=%b ri=%0d re=%b, expected 0 26 0",
                     rev_idx_valid, rev_idx, rev_err);
        end
    endtask

    task automatic test_concurrent();
        fwd_valid = 1'b1; fwd_idx = 6'd2;
        rev_valid = 1'b1; rev_name = 32'h0000_7370;
        step();
        n_cmp++;
        if (fwd_name !== 32'h0000_7370 || rev_idx !== 6'd2 ||
            fwd_name_valid !== 1'b1 || rev_idx_valid !== 1'b1 || fwd_err !== 1'b0 || rev_err !== 1'b0) begin
            n_bad++;
            $display("FAIL concurrent: got fn=%h ri=%0d fv=%b rv=%b, expected 00007370 2 1 1",
                     fwd_name, rev_idx, fwd_name_valid, rev_idx_valid);
        end
        fwd_valid = 1'b0; rev_valid = 1'b0;
    endtask

    task automatic test_round_trip();
        for (int i = 0; i < 32; i++) begin
            fwd_valid = 1'b1; fwd_idx = 6'(i); rev_valid = 1'b0;
            step();
            fwd_valid = 1'b0; rev_valid = 1'b1; rev_name = fwd_name;
            step();
            n_cmp++;
            if (rev_idx !== 6'(i) || rev_err !== 1'b0 || rev_idx_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL round_trip[%0d]: got ri=%0d re=%b rv=%b, expected %0d 0 1",
                         i, rev_idx, rev_err, rev_idx_valid, i);
            end
        end
        rev_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fwd_sweep();
        test_fwd_range();
        test_reverse();
        test_concurrent();
        test_round_trip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
